// File: rtl/flo_alloc_pkg.sv
// Shared types and constants for the 288-entry bitmap free-list allocator.
package flo_alloc_pkg;

  localparam int FLO_N = 288;
  localparam int FLO_W = 9;

  typedef logic [FLO_W-1:0] flo_idx_t;

  // All-ones index means "no entry".
  localparam flo_idx_t FLO_NONE  = 9'd511;
  localparam flo_idx_t FLO_N_IDX = 9'd288;

  typedef enum logic {
    SCAN  = 1'b0,
    READY = 1'b1
  } flo_alloc_state_t;

endpackage

// File: rtl/flo288.sv
// Find-last-one encoder over a 288-bit vector: returns the highest set bit
// index, or FLO_NONE when the vector is all zeros. Two-level search: 18 groups
// of 16 bits each resolve locally, then the highest non-empty group wins.
module flo288
  import flo_alloc_pkg::*;
(
  input  logic [FLO_N-1:0] vec,
  output flo_idx_t         idx
);

  localparam int GRP  = 16;
  localparam int NGRP = FLO_N / GRP;

  logic [NGRP-1:0] grp_any;
  logic [3:0]      grp_pos [NGRP];

  generate
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
      logic [GRP-1:0] slice;
      logic [3:0]     pos;

      assign slice       = vec[gi*GRP +: GRP];
      assign grp_any[gi] = |slice;
      assign grp_pos[gi] = pos;

      // Highest set bit inside this group (later iterations override earlier).
      always_comb begin
        pos = '0;
        for (int b = 0; b < GRP; b++) begin
          if (slice[b]) pos = b[3:0];
        end
      end
    end
  endgenerate

  // Pick the highest non-empty group and combine with its local position.
  always_comb begin
    idx = FLO_NONE;
    for (int g = 0; g < NGRP; g++) begin
      if (grp_any[g]) idx = flo_idx_t'(g * GRP + int'(grp_pos[g]));
    end
  end

endmodule

// File: rtl/flo_bitmap_alloc.sv
// Bitmap free-list manager for a 288-entry pool (1 = free). Allocation grants
// the highest free index found by a registered find-last-one candidate; frees
// set the bit back and flag double frees / out-of-range indices.
// Optional low-water-mark tracking of free_cnt: define FLO_ALLOC_STATS_EN.
module flo_bitmap_alloc
  import flo_alloc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_ack,
  output logic             alloc_fail,
  output logic [FLO_W-1:0] alloc_idx,
  input  logic             free_req,
  input  logic [FLO_W-1:0] free_idx,
  output logic             free_err,
  output logic [FLO_W-1:0] free_cnt,
  output logic [FLO_W-1:0] min_free
);

  logic [FLO_N-1:0] bitmap_reg, bitmap_next;
  logic [FLO_N-1:0] set_vec, clr_vec;
  flo_idx_t         cand_reg, flo_idx;
  logic             cand_v;
  flo_alloc_state_t state_reg, state_next;
  logic             grant, fail_next;
  logic             free_bit, free_ok, free_bad;
  flo_idx_t         free_cnt_reg, free_cnt_next;
  flo_idx_t         alloc_idx_reg;
  logic             alloc_ack_reg, alloc_fail_reg, free_err_reg;

  flo288 u_flo (
    .vec (bitmap_reg),
    .idx (flo_idx)
  );

  assign cand_v = (cand_reg != FLO_NONE);

  // Out-of-range indices behave like an already-free bit so they report an error.
  assign free_bit = (free_idx < FLO_N_IDX) ? bitmap_reg[free_idx] : 1'b1;
  assign free_ok  = free_req && !free_bit;
  assign free_bad = free_req && free_bit;

  // Per-bit decode of the free index (set) and the granted candidate (clear).
  generate
    for (genvar gi = 0; gi < FLO_N; gi++) begin : g_dec
      assign set_vec[gi] = free_ok && (free_idx == flo_idx_t'(gi));
      assign clr_vec[gi] = grant   && (cand_reg == flo_idx_t'(gi));
    end
  endgenerate

  assign bitmap_next = (bitmap_reg | set_vec) & ~clr_vec;

  // Population count moves by at most one per cycle; a simultaneous free and grant cancel.
  always_comb begin
    free_cnt_next = free_cnt_reg;
    case ({free_ok, grant})
      2'b10:   free_cnt_next = free_cnt_reg + 9'd1;
      2'b01:   free_cnt_next = free_cnt_reg - 9'd1;
      default: free_cnt_next = free_cnt_reg;
    endcase
  end

  // FSM next-state: SCAN gives cand one cycle to catch up after every grant/fail.
  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    fail_next  = 1'b0;
    case (state_reg)
      SCAN:  state_next = READY;
      READY: begin
        if (alloc_req) begin
          grant      = cand_v;
          fail_next  = !cand_v;
          state_next = SCAN;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= SCAN;
    else     state_reg <= state_next;
  end

  // Bitmap, candidate, counter and response pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_reg     <= '1;
      cand_reg       <= FLO_NONE;
      free_cnt_reg   <= FLO_N_IDX;
      alloc_idx_reg  <= FLO_NONE;
      alloc_ack_reg  <= 1'b0;
      alloc_fail_reg <= 1'b0;
      free_err_reg   <= 1'b0;
    end else begin
      bitmap_reg     <= bitmap_next;
      cand_reg       <= flo_idx;
      free_cnt_reg   <= free_cnt_next;
      alloc_ack_reg  <= grant;
      alloc_fail_reg <= fail_next;
      free_err_reg   <= free_bad;
      if (grant) alloc_idx_reg <= cand_reg;
    end
  end

`ifdef FLO_ALLOC_STATS_EN
  flo_idx_t min_free_reg;

  // Low-water mark of the free count, tracked against the value being loaded.
  always_ff @(posedge clk) begin
    if (rst)                               min_free_reg <= FLO_N_IDX;
    else if (free_cnt_next < min_free_reg) min_free_reg <= free_cnt_next;
  end

  assign min_free = min_free_reg;
`else
  assign min_free = 9'd0;
`endif

  assign alloc_ack  = alloc_ack_reg;
  assign alloc_fail = alloc_fail_reg;
  assign alloc_idx  = alloc_idx_reg;
  assign free_err   = free_err_reg;
  assign free_cnt   = free_cnt_reg;

endmodule

// File: doc/flo_bitmap_alloc.md
Name: flo_bitmap_alloc

Overview:
- Free-list manager for a 288-entry resource pool, e.g. physical registers or buffer tags; one bitmap bit per entry, 1 = free.
- Allocate: the find-last-one search picks the highest free index, returns it and clears its bit.
- Free: the index is decoded back into the bitmap and the bit is set again.
- Sits between the rename/issue logic (allocate side) and the retire/writeback logic (free side).

Parameters:
- N, 288, number of pool entries.
- W, 9, index width; the all-ones value 511 means "none".

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- alloc_req  in  1  allocation request; held until alloc_ack or alloc_fail.
- alloc_ack  out  1  one-cycle pulse; alloc_idx is valid.
- alloc_fail  out  1  one-cycle pulse; pool empty at the time of the request.
- alloc_idx  out  W  granted index.
- free_req  in  1  single-cycle free strobe.
- free_idx  in  W  index to free.
- free_err  out  1  one-cycle pulse; double free or index >= N.
- free_cnt  out  W  number of free entries.
- min_free  out  W  low-water mark of free_cnt (optional feature).

Behaviour:
- Reset values: bitmap all ones; free_cnt=288; alloc_ack=0; alloc_fail=0; free_err=0; alloc_idx=511; state=SCAN; min_free=288.
- Reset mid-operation discards any pending request; no ack or fail is issued for it.
- Candidate: each cycle cand <= flo(bitmap) registered; cand_v = (flo != 511).
- States:
  - SCAN: one cycle, lets cand reflect the current bitmap; always -> READY.
  - READY, alloc_req && cand_v: next cycle alloc_ack=1, alloc_idx=cand, bitmap[cand] cleared; -> SCAN.
  - READY, alloc_req && !cand_v: next cycle alloc_fail=1; -> SCAN.
  - READY, !alloc_req: stay in READY.
- Allocation latency:
  - 1 cycle from sampling alloc_req in READY.
  - Back-to-back allocations are granted every 2 cycles at most.
- Invariant: in READY, cand always points at a bit that is currently free. Only allocations clear bits, and every allocation forces SCAN.
- Free path, every cycle and in any state:
  - If free_req and free_idx < N and the bitmap bit is 0: set the bit.
  - Otherwise (bit already 1, or free_idx >= N): pulse free_err the next cycle; bitmap unchanged.
- Alloc and free in the same cycle: both apply.
  - A free of the index being granted is a double free: free_err is pulsed, the grant proceeds and the bit ends cleared.
- A free during READY does not refresh cand. The grant may be a lower free index than the true highest; this is legal.
- free_cnt arithmetic:
  - +1 on a valid free, −1 on a grant, unchanged when both occur.
  - Never wraps; range 0..288 holds by construction.
- alloc_idx holds its last granted value between grants.

Optional Feature:
- FLO_ALLOC_STATS_EN defined:
  - min_free register, reset 288.
  - Each cycle: min_free <= min(min_free, free_cnt_next), where free_cnt_next is the free_cnt value being loaded that cycle.
- Undefined: min_free tied to 9'd0; no register is implemented.

Decomposition:
- Package flo_alloc_pkg:
  - FLO_N=288, FLO_W=9, FLO_NONE=9'd511.
  - typedef flo_idx_t (logic [8:0]).
  - state enum flo_alloc_state_t {SCAN, READY}.
- Sub-module: instantiate the existing flo288 find-last-one encoder for the candidate search. The bitmap update, counters and FSM stay in this block.

Test Plan:
- Reset, then three allocs with req held → acks return idx 287, 286, 285, each 1 cycle after READY, with 2-cycle spacing; free_cnt=285.
- Allocate all 288 entries, then one more alloc_req → alloc_fail pulse, alloc_idx stays 0, free_cnt=0.
- From the empty pool: free 100 → free_cnt=1; next alloc → ack with idx 100.
- Double free of 5 while bit 5 is free; free of idx 300 → free_err pulses twice, free_cnt unchanged.
- Same cycle: grant cand=287 and free 287 → alloc_ack idx 287 plus free_err, bitmap[287]=0, free_cnt=287. Separate case: grant 286 with free of 10 (allocated) → free_cnt unchanged.
- Assert rst during a pending alloc_req → no ack, bitmap all ones, free_cnt=288. With FLO_ALLOC_STATS_EN: after 5 allocs and 5 frees, min_free=283.
